timer_counter: RTL
==================

Name: timer_counter

Overview:
- Counting stage directly downstream of the timer APB register block.
- Consumes timer_en, div_en, clk_div, TDR, TDR_sel and halt_req from the register block, plus dbg_mode from the system.
- Produces the free-running 64-bit cnt that the register block reads back and compares against TCMP for interrupt generation.
- Contains a prescaler, a load path, wrap-around and a debug-halt state machine.

Parameters:
- CNT_W, 64, counter width; must equal the TDR width.
- DIV_W, 8, prescaler width; must equal the clk_div width.

Ports:
- sys_clk  input  1  system clock; all logic is on its rising edge.
- sys_rst  input  1  reset, synchronous, active-high.
- timer_en  input  1  counter enable (TCR[0]).
- div_en  input  1  prescaler enable (TCR[1]).
- clk_div  input  DIV_W  prescaler terminal value, (1<<div_val)-1; 0 means divide by 1.
- TDR  input  CNT_W  load value {TDR1,TDR0}.
- TDR_sel  input  1  one-cycle load strobe; asserted the cycle after an APB write to TDR0 or TDR1.
- halt_req  input  1  debug halt request (THCSR[0]).
- dbg_mode  input  1  system debug mode qualifier.
- cnt  output  CNT_W  current count.
- cnt_tick  output  1  one-cycle pulse on each increment.
- halt_ack  output  1  high while in the HALT state.
- state_o  output  2  FSM state for debug: 00 IDLE, 01 RUN, 10 HALT.

Behaviour:
- Reset (sys_rst=1 at a clock edge):
  - cnt=0, prescaler div_cnt=0, state=IDLE.
  - cnt_tick=0, halt_ack=0, state_o=00.
  - Reset overrides every other input.
- FSM transitions are evaluated each cycle in the order listed; the first match wins:
  - any state -> HALT when halt_req&&dbg_mode.
  - HALT -> RUN when !(halt_req&&dbg_mode) && timer_en.
  - HALT -> IDLE when !(halt_req&&dbg_mode) && !timer_en.
  - IDLE -> RUN when timer_en.
  - RUN -> IDLE when !timer_en.
- halt_ack is a registered output: it equals (next state == HALT) one cycle after the request.
- Tick generation, evaluated only in RUN:
  - eff_div = div_en ? clk_div : 0.
  - If div_cnt >= eff_div: tick=1 and div_cnt<=0.
  - Otherwise: div_cnt<=div_cnt+1 and tick=0.
  - The >= comparison means a reduced clk_div takes effect with no stall.
  - Increment period is eff_div+1 cycles.
  - The first tick after IDLE->RUN occurs eff_div+1 cycles after the state enters RUN.
- Count update:
  - On tick, cnt<=cnt+1 modulo 2^CNT_W.
  - 0xFFFF_FFFF_FFFF_FFFF wraps to 0; no saturation.
  - cnt_tick is registered and high in the same cycle cnt shows the new value.
- Load:
  - TDR_sel=1 gives cnt<=TDR and div_cnt<=0 in any state, including IDLE and HALT.
  - Load has priority over a same-cycle tick: no increment, cnt_tick=0.
- IDLE:
  - cnt holds its value; div_cnt is forced to 0.
  - The register block reads TDR while disabled, so cnt is not cleared here.
- HALT:
  - cnt and div_cnt freeze, apart from load.
  - On exit to RUN, prescaling resumes from the frozen div_cnt.
- Simultaneous events:
  - halt request and tick in the same cycle: the halt wins and no increment occurs.
  - timer_en falling and TDR_sel in the same cycle: the load is applied and the state goes to IDLE.
- Reset mid-count: cnt clears at the next edge, even during HALT.
- No combinational path from any input to any output.

Optional Feature:
- Macro: TIMER_CNT_OVF_EN.
- When defined:
  - Adds output port cnt_ovf (1 bit).
  - cnt_ovf is a registered one-cycle pulse, coincident with cnt_tick, when cnt wraps from all-ones to 0.
  - cnt_ovf is cleared by reset.
  - A load of all-ones does not pulse cnt_ovf.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic count: reset, then timer_en=1, div_en=0 -> cnt goes 1,2,3 on consecutive cycles starting 1 cycle after RUN is entered; cnt_tick high each cycle.
- Prescaler: div_en=1, clk_div=8'h03 -> cnt increments every 4 cycles; then clk_div changes to 8'h00 while div_cnt=2 -> tick on the next cycle, then every cycle.
- Load vs tick: TDR=64'h0000_0001_FFFF_FFFE, TDR_sel pulse in a tick cycle -> cnt=0x1_FFFF_FFFE, cnt_tick=0; the next tick gives 0x1_FFFF_FFFF, then 0x2_0000_0000.
- Wrap: load all-ones with timer_en=1, div_en=0 -> next cnt=0; with TIMER_CNT_OVF_EN, cnt_ovf=1 for exactly that cycle.
- Debug halt:
  - halt_req=1, dbg_mode=0 -> no halt, counting continues.
  - dbg_mode=1 -> halt_ack=1 next cycle, cnt frozen.
  - TDR_sel with TDR=0x10 while halted -> cnt=0x10.
  - Drop halt_req -> RUN resumes and cnt=0x11 after one period.
- Disable/reset: timer_en=0 at cnt=0x50 -> IDLE, cnt holds 0x50; sys_rst=1 during HALT -> cnt=0, state_o=00, halt_ack=0 after the edge.

Source files
------------

// File: rtl/timer_counter.sv
// timer_counter: prescaled CNT_W-bit up-counter with TDR load, wrap-around and a debug-halt FSM.
// Define TIMER_CNT_OVF_EN to add the cnt_ovf wrap pulse output.
module timer_counter #(
    parameter int CNT_W = 64,
    parameter int DIV_W = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             timer_en,
    input  logic             div_en,
    input  logic [DIV_W-1:0] clk_div,
    input  logic [CNT_W-1:0] TDR,
    input  logic             TDR_sel,
    input  logic             halt_req,
    input  logic             dbg_mode,
    output logic [CNT_W-1:0] cnt,
    output logic             cnt_tick,
    output logic             halt_ack,
`ifdef TIMER_CNT_OVF_EN
    output logic             cnt_ovf,
`endif
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t           state_p1;
    state_t           state_nxt_p0;
    logic [DIV_W-1:0] div_cnt_p1;
    logic [DIV_W-1:0] eff_div_p0;
    logic             halt_p0;
    logic             run_p0;
    logic             div_hit_p0;
    logic             tick_p0;

    function automatic logic [CNT_W-1:0] cnt_wrap_inc(input logic [CNT_W-1:0] v);
        return v + CNT_W'(1);
    endfunction

    function automatic logic cnt_is_max(input logic [CNT_W-1:0] v);
        return &v;
    endfunction

    // Stage p0: next-state and tick decode from the current registered state.
    always_comb begin
        halt_p0      = halt_req && dbg_mode;
        state_nxt_p0 = state_p1;
        if (halt_p0) begin
            state_nxt_p0 = HALT;
        end else begin
            case (state_p1)
                HALT:    state_nxt_p0 = timer_en ? RUN : IDLE;
                IDLE:    if (timer_en) state_nxt_p0 = RUN;
                RUN:     if (!timer_en) state_nxt_p0 = IDLE;
                default: state_nxt_p0 = IDLE;
            endcase
        end
    end

    always_comb begin
        eff_div_p0 = div_en ? clk_div : '0;
        // Counting only while staying in RUN, so a halt or disable suppresses the tick.
        run_p0     = (state_p1 == RUN) && (state_nxt_p0 == RUN);
        div_hit_p0 = div_cnt_p1 >= eff_div_p0;
        tick_p0    = run_p0 && div_hit_p0;
    end

    // Stage p1: state register and its registered status outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_p1 <= IDLE;
            halt_ack <= 1'b0;
        end else begin
            state_p1 <= state_nxt_p0;
            halt_ack <= (state_nxt_p0 == HALT);
        end
    end

    assign state_o = state_p1;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt        <= '0;
            div_cnt_p1 <= '0;
            cnt_tick   <= 1'b0;
        end else begin
            cnt_tick <= tick_p0 && !TDR_sel;
            if (TDR_sel) begin
                cnt        <= TDR;
                div_cnt_p1 <= '0;
            end else begin
                if (tick_p0) begin
                    cnt <= cnt_wrap_inc(cnt);
                end
                // HALT entry/exit cycles keep div_cnt so prescaling resumes where it stopped.
                if (run_p0) begin
                    div_cnt_p1 <= div_hit_p0 ? '0 : div_cnt_p1 + DIV_W'(1);
                end else if ((state_p1 == IDLE) || (state_nxt_p0 == IDLE)) begin
                    div_cnt_p1 <= '0;
                end
            end
        end
    end

`ifdef TIMER_CNT_OVF_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_ovf <= 1'b0;
        end else begin
            cnt_ovf <= tick_p0 && !TDR_sel && cnt_is_max(cnt);
        end
    end
`else
    logic unused_max_p0;
    assign unused_max_p0 = cnt_is_max(cnt);
`endif

endmodule
